scope_capture_buffer: RTL and testbench

Sample capture stage of the oscilloscope: it takes the ADC sample stream, detects a trigger crossing, and records a frame of `DEPTH` samples into a back bank while the display reads the stable front bank. Banks swap only at a video frame boundary, so a displayed trace never tears. It sits upstream of the sample-to-pixel conversion: the display strobe x coordinate addresses `i_rd_addr`, and `o_rd_data` feeds the data-to-pixel mapping.

---
 rtl/scope_capture_buffer.sv | 140 ++++++++++++++
 tb/tb_scope_capture_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_buffer.sv
// scope_capture_buffer
//   Double-banked oscilloscope capture. Watches the ADC stream for a trigger
//   crossing (or an auto timeout), records DEPTH samples into the back bank,
//   then swaps banks on the next video frame start so the display never
//   sees a half-written trace.
// Ports
//   i_clk, i_rst_n           clock, async active-low reset
//   i_sample_valid/i_sample  ADC stream (unsigned)
//   i_trigger_level/_rising  trigger threshold and edge direction
//   i_auto, i_continuous     auto-trigger enable, re-arm after each swap
//   i_arm                    one-cycle arm request (honoured in IDLE only)
//   i_frame_start            one-cycle video frame boundary pulse
//   i_rd_addr / o_rd_data    display read port, 1-cycle latency, front bank
//   o_armed, o_capturing     registered state decodes
//   o_frame_valid            sticky after first swap
//   o_swapped                one-cycle pulse on a swap edge
module scope_capture_buffer #(
  parameter int DEPTH        = 640,
  parameter int DATA_W       = 10,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_trigger_level,
  input  logic              i_trigger_rising,
  input  logic              i_auto,
  input  logic              i_continuous,
  input  logic              i_arm,
  input  logic              i_frame_start,
  input  logic [9:0]        i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_armed,
  output logic              o_capturing,
  output logic              o_frame_valid,
  output logic              o_swapped
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(AUTO_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, WAIT_SWAP} state_t;

  state_t            state, state_n;
  logic              front;
  logic              frame_valid;
  logic              prev_valid;
  logic [DATA_W-1:0] prev;
  logic [TW-1:0]     tcnt;
  logic [AW-1:0]     waddr;

  // front = 0: display bank0, capture into bank1 (and vice versa)
  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic          edge_hit, auto_hit, trig, we, last_wr, do_swap, enter_armed;
  logic [AW-1:0] wa;
  logic [AW-1:0] ridx;

  always_comb begin
    edge_hit = prev_valid &&
               (i_trigger_rising ? (prev < i_trigger_level && i_sample >= i_trigger_level)
                                 : (prev > i_trigger_level && i_sample <= i_trigger_level));
    auto_hit = i_auto && (tcnt == T_LAST);
    trig     = (state == ARMED) && i_sample_valid && (edge_hit || auto_hit);
    // triggering sample goes straight to address 0 on the same edge
    we       = trig || ((state == CAPTURE) && i_sample_valid);
    wa       = trig ? '0 : waddr;
    last_wr  = we && (wa == A_LAST);
    // a frame_start coinciding with the last write sees CAPTURE, not WAIT_SWAP
    do_swap  = (state == WAIT_SWAP) && i_frame_start;

    state_n = state;
    case (state)
      IDLE:      if (i_arm)   state_n = ARMED;
      ARMED:     if (trig)    state_n = last_wr ? WAIT_SWAP : CAPTURE;
      CAPTURE:   if (last_wr) state_n = WAIT_SWAP;
      WAIT_SWAP: if (do_swap) state_n = i_continuous ? ARMED : IDLE;
      default:                state_n = IDLE;
    endcase
    enter_armed = (state_n == ARMED) && (state != ARMED);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      front       <= 1'b0;
      frame_valid <= 1'b0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      tcnt        <= '0;
      waddr       <= '0;
      o_armed     <= 1'b0;
      o_capturing <= 1'b0;
      o_swapped   <= 1'b0;
    end else begin
      state       <= state_n;
      o_armed     <= (state_n == ARMED);
      o_capturing <= (state_n == CAPTURE);
      o_swapped   <= do_swap;
      if (do_swap) begin
        front       <= ~front;
        frame_valid <= 1'b1;
      end
      if (enter_armed) begin
        prev_valid <= 1'b0;
        tcnt       <= '0;
        waddr      <= '0;
      end else if ((state == ARMED) && i_sample_valid) begin
        prev       <= i_sample;
        prev_valid <= 1'b1;
        // holds at the terminal count so a late i_auto still fires
        if (tcnt != T_LAST) tcnt <= tcnt + 1'b1;
      end
      if (we) waddr <= last_wr ? '0 : wa + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (we) begin
      if (front) bank0[wa] <= i_sample;
      else       bank1[wa] <= i_sample;
    end
  end

  assign ridx = AW'(i_rd_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_rd_data <= '0;
    else if (frame_valid && (32'(i_rd_addr) < DEPTH))
      o_rd_data <= front ? bank1[ridx] : bank0[ridx];
    else
      o_rd_data <= '0;
  end

  assign o_frame_valid = frame_valid;
endmodule

// File: tb/tb_scope_capture_buffer.sv
module tb_scope_capture_buffer;
  localparam int DEPTH = 640;
  localparam int DW    = 10;
  localparam int AT    = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sample_valid = 0, trigger_rising = 0, auto_en = 0;
  logic          continuous = 0, arm = 0, frame_start = 0;
  logic [DW-1:0] sample = '0, trigger_level = '0;
  logic [9:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          armed, capturing, frame_valid, swapped;

  scope_capture_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .AUTO_TIMEOUT(AT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sample_valid), .i_sample(sample),
    .i_trigger_level(trigger_level), .i_trigger_rising(trigger_rising), .i_auto(auto_en),
    .i_continuous(continuous), .i_arm(arm), .i_frame_start(frame_start), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_armed(armed), .o_capturing(capturing),
    .o_frame_valid(frame_valid), .o_swapped(swapped)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int exp_front[DEPTH];   // model of what the display bank should show
  bit fv = 0;             // model frame_valid
  int pre_q[$];           // fixed stimulus prefix for the next capture

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int a);
    if (fv && a < DEPTH) return exp_front[a];
    return 0;
  endfunction

  function automatic int rand_addr();
    if ($urandom_range(3) == 0) return $urandom_range(1023);
    return $urandom_range(DEPTH-1);
  endfunction

  // one clock: apply inputs, let an edge pass, check the registered read
  task automatic step(input bit v, input int s, input bit a_rm, input bit fs, input int a,
                      input string tag);
    sample_valid = v; sample = s[DW-1:0]; arm = a_rm; frame_start = fs; rd_addr = a[9:0];
    @(negedge clk);
    chk({tag, "_rd"}, rd_data, exp_read(a));
    sample_valid = 0; arm = 0; frame_start = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_rd", rd_data, 0);
    chk("rst_armed", armed, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_swapped", swapped, 0);
    fv = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // mode: 0 ramp 10*i mod 1024, 1 constant 100, 2 random; prefix from pre_q
  task automatic run_capture(input bit rising, input int level, input bit au, input bit cont,
                             input bit do_arm, input int mode, input bit fs_last,
                             input int vpct, input int abort_at);
    int smp[$]; bit vld[$]; int vs[$];
    int t, n, extra, tries, prv, cnt;
    bit pv;
    trigger_level = level[DW-1:0]; trigger_rising = rising; auto_en = au; continuous = cont;
    tries = 0;
    do begin
      smp.delete(); vld.delete(); vs.delete();
      foreach (pre_q[i]) begin smp.push_back(pre_q[i]); vld.push_back(1'b1); end
      for (int i = 0; i < DEPTH + 600; i++) begin
        int j;
        j = i + pre_q.size();
        vld.push_back($urandom_range(99) < vpct);
        case (mode)
          0:       smp.push_back((10 * j) % 1024);
          1:       smp.push_back(100);
          default: smp.push_back($urandom_range(1023));
        endcase
      end
      foreach (smp[i]) if (vld[i]) vs.push_back(smp[i]);
      // trigger scan straight from the crossing / timeout rules
      t = -1; pv = 0; prv = 0; cnt = 0;
      for (int k = 0; k < vs.size(); k++) begin
        bit e;
        e = pv && (rising ? (prv < level && vs[k] >= level) : (prv > level && vs[k] <= level));
        if (e || (au && cnt == AT - 1)) begin t = k; break; end
        prv = vs[k]; pv = 1; cnt++;
      end
      tries++;
    end while ((t < 0 || t + DEPTH > vs.size()) && tries < 20);
    if (t < 0 || t + DEPTH > vs.size()) begin
      $display("FAIL stim: no usable trigger in generated stream");
      $fatal(1);
    end

    if (do_arm) begin
      step(0, 0, 1, 0, rand_addr(), "arm");
      chk("armed_after_arm", armed, 1);
    end
    n = 0; extra = 0;
    foreach (smp[i]) begin
      bit last, fs;
      last = vld[i] && (n + 1 == t + DEPTH);
      // stray frame_start pulses outside WAIT_SWAP must be ignored
      fs = (n < t + DEPTH) && ((fs_last && last) || $urandom_range(15) == 0);
      step(vld[i], smp[i], 0, fs, rand_addr(), "cap");
      if (vld[i]) n++;
      chk("armed", armed, n <= t);
      chk("capturing", capturing, n > t && n < t + DEPTH);
      chk("swapped_early", swapped, 0);
      chk("frame_valid", frame_valid, fv);
      if (abort_at >= 0 && n == t + abort_at) begin
        do_reset();
        return;
      end
      if (n >= t + DEPTH) begin
        extra++;
        if (extra > 3) break;
      end
    end
    if (n < t + DEPTH) chk("stream_short", n, t + DEPTH);

    step(0, 0, 0, 1, rand_addr(), "swap");
    chk("swapped_pulse", swapped, 1);
    for (int i = 0; i < DEPTH; i++) exp_front[i] = vs[t + i];
    fv = 1;
    chk("frame_valid_set", frame_valid, 1);
    chk("armed_after_swap", armed, cont);
    chk("cap_after_swap", capturing, 0);
    step(0, 0, 0, 0, rand_addr(), "post");
    chk("swapped_once", swapped, 0);
    for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 0, a, "sweep");
    step(0, 0, 0, 0, 640, "oob640");
    step(0, 0, 0, 0, 700, "oob700");
    step(0, 0, 0, 0, 1023, "oob1023");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state and no data before the first swap
    #1;
    chk("por_armed", armed, 0);
    chk("por_rd", rd_data, 0);
    @(negedge clk); rst_n = 1;
    step(0, 0, 0, 0, 5, "first_rd5");
    chk("first_fv", frame_valid, 0);

    // rising ramp: triggers on 520 after 510
    pre_q.delete();
    run_capture(1, 512, 0, 0, 1, 0, 0, 100, -1);

    // falling: 600 then 512 triggers on the equal sample
    pre_q = '{600, 512};
    run_capture(0, 512, 0, 0, 1, 2, 0, 80, -1);

    // rising: 512,512 never cross (prev not strictly below); random tail decides
    pre_q = '{512, 512, 600};
    run_capture(1, 512, 0, 0, 1, 2, 0, 80, -1);

    // auto trigger on the AT-th valid sample of a flat input
    pre_q.delete();
    run_capture(1, 50, 1, 0, 1, 1, 0, 70, -1);

    // no auto: flat input keeps the block armed
    auto_en = 0; trigger_level = 50; trigger_rising = 1;
    step(0, 0, 1, 0, rand_addr(), "hold_arm");
    for (int i = 0; i < 60; i++) begin
      step(1, 100, 0, 0, rand_addr(), "hold");
      chk("hold_armed", armed, 1);
      chk("hold_capturing", capturing, 0);
    end
    do_reset();

    // frame_start on the last write is not a swap
    run_capture(1, 300, 0, 0, 1, 2, 1, 90, -1);

    // reset at capture address 300 drops the partial frame
    run_capture(1, 512, 0, 0, 1, 0, 0, 100, 300);
    step(0, 0, 0, 0, 5, "after_abort");
    chk("abort_armed", armed, 0);
    chk("abort_fv", frame_valid, 0);

    // continuous: two back-to-back frames, then stop
    run_capture(1, 400, 0, 1, 1, 2, 0, 85, -1);
    run_capture(0, 600, 0, 1, 0, 2, 0, 85, -1);
    run_capture(1, 200, 0, 0, 0, 2, 0, 85, -1);

    // random mix
    for (int it = 0; it < 6; it++)
      run_capture($urandom_range(1), $urandom_range(100, 900), $urandom_range(1), 0, 1, 2,
                  $urandom_range(1), $urandom_range(50, 100), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
